iiitb_pwm_decoder: RTL and testbench

//  Receive side of the PWM link: measures an incoming PWM waveform and reports duty cycle
//  in tenths (0..10), plus raw high time and period in clk cycles.

---
 rtl/iiitb_pwm_decoder_pkg.sv | 21 ++
 rtl/iiitb_pwm_duty_div.sv | 80 ++++++++
 rtl/iiitb_pwm_decoder.sv | 127 ++++++++++++
 tb/tb_iiitb_pwm_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_pwm_decoder_pkg.sv
// Shared types and constants for the PWM receive path.
// Decoder and duty divider state encodings live here so both files agree.
package iiitb_pwm_decoder_pkg;

  localparam int DUTY_MAX = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2,
    STUCK     = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_LOAD = 2'd1,
    DIV_SUB  = 2'd2,
    DIV_PUB  = 2'd3
  } div_state_t;

endpackage

// File: rtl/iiitb_pwm_duty_div.sv
// Duty divider: q = min(10, floor((10*high + period/2) / period)), one subtraction per cycle.
// Busy for q+2 cycles (load, q subtracts, publish); done marks the edge that publishes q.
module iiitb_pwm_duty_div
  import iiitb_pwm_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [3:0]       q
);

  localparam int NUM_W = CNT_W + 4;

  div_state_t       state;
  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] per;
  logic [3:0]       q_acc;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] rem_sub;
  logic [3:0]       q_inc;
  logic             last_sub;

  // 10*high built from shifts; period/2 gives round-to-nearest.
  assign num      = ({4'b0, high} << 3) + ({4'b0, high} << 1) + NUM_W'(period >> 1);
  assign rem_sub  = rem - per;
  assign q_inc    = q_acc + 4'd1;
  assign last_sub = (rem_sub < per) || (q_inc == 4'(DUTY_MAX));
  assign busy     = (state != DIV_IDLE);

  // done leads the publish cycle by one edge so the top's registered outputs
  // become visible exactly in the last busy cycle.
  always_comb begin
    done = 1'b0;
    q    = q_acc;
    if (state == DIV_LOAD && rem < per) begin
      done = 1'b1;
    end else if (state == DIV_SUB && last_sub) begin
      done = 1'b1;
      q    = q_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      rem   <= '0;
      per   <= '0;
      q_acc <= '0;
    end else if (abort) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem   <= num;
            per   <= {4'b0, period};
            q_acc <= '0;
            state <= DIV_LOAD;
          end
        end
        DIV_LOAD: state <= (rem < per) ? DIV_PUB : DIV_SUB;
        DIV_SUB: begin
          rem   <= rem_sub;
          q_acc <= q_inc;
          if (last_sub) state <= DIV_PUB;
        end
        DIV_PUB: state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/iiitb_pwm_decoder.sv
// PWM receiver: synchronises pwm_in, measures high time and period, publishes duty in tenths,
// and reports an edge-less input as stuck.
module iiitb_pwm_decoder
  import iiitb_pwm_decoder_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [3:0]       duty_tenths,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             duty_valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  dec_state_t       state;
  logic [CNT_W-1:0] hi_r;
  logic [CNT_W-1:0] pend_high;
  logic [CNT_W-1:0] pend_period;
  logic             launch_req;
  logic             div_start;
  logic             timeout_hit;
  logic             div_busy;
  logic             div_done;
  logic [3:0]       div_q;

  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign launch_req  = (state == MEAS_LOW) && rise;
  assign div_start   = launch_req && !div_busy;
  // A rise in the same cycle as the timeout keeps the link alive.
  assign timeout_hit = (cnt == TIMEOUT_V) && !rise && (state != STUCK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
      if (rise)                 cnt <= CNT_W'(1);
      else if (cnt != TIMEOUT_V) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hi_r        <= '0;
      pend_high   <= '0;
      pend_period <= '0;
      duty_tenths <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_valid  <= 1'b0;
      stuck       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (timeout_hit) begin
        state <= STUCK;
      end else begin
        case (state)
          IDLE:      if (rise) state <= MEAS_HIGH;
          MEAS_HIGH: if (fall) begin
            hi_r  <= cnt;
            state <= MEAS_LOW;
          end
          MEAS_LOW:  if (rise) state <= MEAS_HIGH;
          STUCK: begin
            if (rise)      state <= MEAS_HIGH;
            else if (fall) state <= IDLE;
          end
          default:   state <= IDLE;
        endcase
      end

      if (div_start) begin
        pend_high   <= hi_r;
        pend_period <= cnt;
      end
      if (launch_req && div_busy) overrun <= 1'b1;

      // The stuck report takes priority over a divider result landing on the same edge.
      if (timeout_hit) begin
        duty_tenths <= s2 ? 4'(DUTY_MAX) : 4'd0;
        high_cnt    <= s2 ? TIMEOUT_V : '0;
        period_cnt  <= TIMEOUT_V;
        stuck       <= 1'b1;
        duty_valid  <= 1'b1;
      end else if (div_done) begin
        duty_tenths <= div_q;
        high_cnt    <= pend_high;
        period_cnt  <= pend_period;
        stuck       <= 1'b0;
        duty_valid  <= 1'b1;
      end
    end
  end

  iiitb_pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (reset),
    .start  (div_start),
    .abort  (timeout_hit),
    .high   (hi_r),
    .period (cnt),
    .busy   (div_busy),
    .done   (div_done),
    .q      (div_q)
  );

endmodule

// File: tb/tb_iiitb_pwm_decoder.sv
// Directed bench for the PWM decoder: every duty_valid pulse is logged with its cycle
// and compared against hand-computed publish times and values.
module tb_iiitb_pwm_decoder;

  logic        clk;
  logic        reset;
  logic        pwm_in;
  logic [3:0]  duty_tenths;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic        duty_valid;
  logic        stuck;
  logic        overrun;

  int cyc;
  int vectors;
  int miscompares;

  typedef struct {
    int cyc;
    int duty;
    int high;
    int period;
    int stk;
    int ovr;
  } ev_t;

  ev_t ev_q[$];

  iiitb_pwm_decoder #(
    .CNT_W   (16),
    .TIMEOUT (1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .duty_tenths (duty_tenths),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .duty_valid  (duty_valid),
    .stuck       (stuck),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      ev_q.push_back('{cyc: cyc, duty: int'(duty_tenths), high: int'(high_cnt),
                       period: int'(period_cnt), stk: int'(stuck), ovr: int'(overrun)});
      $display("publish cyc=%0d duty=%0d high=%0d period=%0d stuck=%0d overrun=%0d",
               cyc, duty_tenths, high_cnt, period_cnt, stuck, overrun);
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_train(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(per - hi);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic expect_events(input string tag, input int n_exp, input int first_cyc,
                               input int gap, input int duty, input int hi, input int per,
                               input int stk, input int ovr);
    check_vec($sformatf("%s.count", tag), ev_q.size(), n_exp);
    for (int i = 0; i < ev_q.size() && i < n_exp; i++) begin
      check_vec($sformatf("%s[%0d].cyc", tag, i), ev_q[i].cyc, first_cyc + i * gap);
      check_vec($sformatf("%s[%0d].duty", tag, i), ev_q[i].duty, duty);
      check_vec($sformatf("%s[%0d].high", tag, i), ev_q[i].high, hi);
      check_vec($sformatf("%s[%0d].period", tag, i), ev_q[i].period, per);
      check_vec($sformatf("%s[%0d].stuck", tag, i), ev_q[i].stk, stk);
      check_vec($sformatf("%s[%0d].overrun", tag, i), ev_q[i].ovr, ovr);
    end
    ev_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, ".duty"}, duty_tenths, 0);
    check_vec({tag, ".high"}, high_cnt, 0);
    check_vec({tag, ".period"}, period_cnt, 0);
    check_vec({tag, ".valid"}, duty_valid, 0);
    check_vec({tag, ".stuck"}, stuck, 0);
    check_vec({tag, ".overrun"}, overrun, 0);
  endtask

  initial begin
    int c0;
    int crel;
    clk         = 1'b0;
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    pwm_in      = 1'b0;
    tick(3);
    check_all_zero("rst");
    reset = 1'b0;
    tick(2);

    // Period 10, high 5: publish 2nd rise + 7, rise lags pwm_in by 2 cycles.
    c0 = cyc;
    pulse_train(5, 10, 3);
    tick(15);
    expect_events("p10h5", 2, c0 + 19, 10, 5, 5, 10, 0, 0);
    check_vec("p10h5.overrun_end", overrun, 0);

    // Period 20, high 7: num 80 -> q 4, busy 6.
    do_reset();
    c0 = cyc;
    pulse_train(7, 20, 3);
    tick(15);
    expect_events("p20h7", 2, c0 + 28, 20, 4, 7, 20, 0, 0);
    check_vec("p20h7.overrun_end", overrun, 0);

    // Single period 3, high 1: num 11 -> q 3, busy 5.
    do_reset();
    c0 = cyc;
    pulse_train(1, 3, 2);
    tick(15);
    expect_events("p3h1", 1, c0 + 10, 0, 3, 1, 3, 0, 0);
    check_vec("p3h1.overrun_end", overrun, 0);

    // Period 10, high 9: busy 11 > 10, every second launch dropped.
    do_reset();
    c0 = cyc;
    pulse_train(9, 10, 5);
    tick(20);
    expect_events("p10h9", 2, c0 + 23, 20, 9, 9, 10, 0, 1);
    check_vec("p10h9.overrun_end", overrun, 1);

    // Held high from reset: rise at release+2, timeout 1000 cycles later.
    reset  = 1'b1;
    pwm_in = 1'b1;
    tick(3);
    reset = 1'b0;
    crel  = cyc;
    tick(1010);
    expect_events("held1", 1, crel + 1003, 0, 10, 1000, 1000, 1, 0);

    // Held low from reset: cnt reaches TIMEOUT at release+1000.
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    crel  = cyc;
    tick(1010);
    expect_events("held0", 1, crel + 1001, 0, 0, 0, 1000, 1, 0);
    check_vec("held0.stuck_hold", stuck, 1);

    // Recovery from STUCK with period 10, high 3: num 35 -> q 3.
    c0 = cyc;
    pulse_train(3, 10, 3);
    tick(15);
    expect_events("recover", 2, c0 + 17, 10, 3, 3, 10, 0, 0);
    check_vec("recover.stuck_end", stuck, 0);

    // Reset while in MEAS_LOW with the divider mid-subtract.
    do_reset();
    c0 = cyc;
    pulse_train(1, 10, 3);
    pwm_in = 1'b1;
    tick(1);
    pwm_in = 1'b0;
    tick(3);
    check_vec("midrst.when", cyc, c0 + 34);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    tick(3);
    expect_events("midrst.pre", 2, c0 + 15, 10, 1, 1, 10, 0, 0);
    reset = 1'b0;
    tick(2);
    c0 = cyc;
    pulse_train(1, 10, 2);
    tick(20);
    expect_events("midrst.post", 1, c0 + 15, 0, 1, 1, 10, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
